cim_dot_product_engine: RTL and testbench
=========================================

Name: cim_dot_product_engine

Overview:
- Parametrised fixed-point dot-product sequencer for the centralized CIM datapath.
- On a start command it streams LEN element pairs from two single-port read memories: intermediate results (port A) and parameters (port B).
- Accumulates the products at full precision, adds a bias, then rounds, saturates and optionally applies ReLU.
- Generalises the fixed 4b/7b/9b counter scheme to a configurable vector length, data width and memory read latency.

Parameters:
- DATA_W, 16, width of operands, bias and result (signed two's complement).
- FRAC_W, 10, fractional bits of every DATA_W quantity.
- ADDR_W, 12, memory address width for both ports.
- LEN_W, 9, width of the len input; maximum vector length is 2^LEN_W-1.
- MEM_LAT, 1, read latency in cycles (1..4) from registered address/enable to data valid.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  single-cycle command strobe; sampled only in IDLE.
- len  in  LEN_W  number of element pairs; sampled with start.
- base_a  in  ADDR_W  port A start address; sampled with start.
- base_b  in  ADDR_W  port B start address; sampled with start.
- bias  in  DATA_W  Q(DATA_W-FRAC_W).FRAC_W bias; sampled with start.
- act_en  in  1  1 = apply ReLU to the result; sampled with start.
- mem_a_en  out  1  port A read enable.
- mem_a_addr  out  ADDR_W  port A read address.
- mem_a_data  in  DATA_W  port A read data.
- mem_b_en  out  1  port B read enable.
- mem_b_addr  out  ADDR_W  port B read address.
- mem_b_data  in  DATA_W  port B read data.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse; result is valid from this cycle.
- result  out  DATA_W  final value; held until the next done.
- overflow  out  1  saturation occurred; updated with done.

Behaviour:
- Reset (asynchronous): state IDLE. busy, done, mem_a_en, mem_b_en, overflow all 0. result, mem_a_addr, mem_b_addr, accumulator and element counter all 0.
- States: IDLE, FETCH, DRAIN, FINISH.
  - IDLE -> FETCH on start with len != 0.
  - IDLE -> FINISH on start with len == 0.
  - FETCH -> DRAIN after issuing element len-1.
  - DRAIN -> FINISH once the last read data has been accumulated.
  - FINISH -> IDLE unconditionally.
- Command capture: start captures len, base_a, base_b, bias and act_en into internal registers, clears the accumulator and sets busy.
- Start while busy is ignored; no state or registered value changes.
- Fetch:
  - Element k (0..len-1) is issued on cycle 1+k after the start edge: mem_*_en = 1, mem_a_addr = base_a+k, mem_b_addr = base_b+k.
  - Address addition wraps modulo 2^ADDR_W.
  - Enables drop to 0 after the last issue. Addresses hold their last value.
- Valid tracking: a MEM_LAT-deep valid shift register follows each issue. Data for element k is consumed at the edge MEM_LAT cycles after issue.
- Arithmetic:
  - Each product is a full 2*DATA_W signed value in Q(2*FRAC_W).
  - Accumulator width is ACC_W = 2*DATA_W+LEN_W; it cannot overflow internally.
  - FINISH computes sum = acc + (bias sign-extended, shifted left by FRAC_W).
  - Rounding: add 2^(FRAC_W-1), then arithmetic shift right by FRAC_W (round half up).
  - Saturation: clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; overflow = 1 if clamping occurred.
  - ReLU (act_en = 1): negative values become 0, applied after saturation. Overflow reflects saturation only.
- Latency:
  - done is visible len+MEM_LAT+2 cycles after the start edge for len >= 1.
  - done is visible 2 cycles after the start edge for len == 0; result is then round/activation of bias alone.
- Completion: busy drops in the same cycle done rises. A new start is accepted in the cycle done is high (state is IDLE).
- Reset mid-operation: immediate return to the reset state. The in-flight returning memory data is discarded, and no done is generated.

Test Plan:
- FRAC_W=10, MEM_LAT=1, len=4, A=[1024,2048,-1024,512], B=[1024,1024,1024,2048], bias=512 -> result=3584, overflow=0, done exactly 7 cycles after start, addresses base..base+3 issued on consecutive cycles.
- len=255, all A=B=32767, bias=0 -> result=32767, overflow=1; same run with A=-32768, B=32767 -> result=-32768, overflow=1.
- Rounding: len=1, A=1, B=512 (product 0.5 LSB) -> result=1; A=1, B=511 -> result=0.
- ReLU: act_en=1, len=1, A=-1024, B=1024, bias=0 -> result=0, overflow=0; act_en=0 -> result=-1024. len=0, bias=-200, act_en=1 -> result=0, done 2 cycles after start.
- MEM_LAT=3 build, len=2 -> done 7 cycles after start. Start pulsed during busy -> ignored, result unchanged. Back-to-back start on the done cycle -> accepted.
- Assert rst during FETCH of a len=8 run -> all outputs 0 asynchronously, no done pulse. A following start gives the correct result from a cleared accumulator. base_a=4094, len=4 -> addresses 4094, 4095, 0, 1.

Source files
------------

// File: rtl/cim_dot_product_engine_if.sv
// Command, memory-read and status bundle for the CIM dot-product engine.
// The slave side is the engine; the master side is the controller plus the
// two read memories that feed it.
interface cim_dot_product_engine_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int LEN_W  = 9
);
  // Command
  logic              start;
  logic [LEN_W-1:0]  len;
  logic [ADDR_W-1:0] base_a;
  logic [ADDR_W-1:0] base_b;
  logic [DATA_W-1:0] bias;
  logic              act_en;

  // Port A (intermediate results) and port B (parameters) reads
  logic              mem_a_en;
  logic [ADDR_W-1:0] mem_a_addr;
  logic [DATA_W-1:0] mem_a_data;
  logic              mem_b_en;
  logic [ADDR_W-1:0] mem_b_addr;
  logic [DATA_W-1:0] mem_b_data;

  // Status / result
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;
  logic              overflow;

  modport master (
    output start, len, base_a, base_b, bias, act_en, mem_a_data, mem_b_data,
    input  mem_a_en, mem_a_addr, mem_b_en, mem_b_addr, busy, done, result, overflow
  );

  modport slave (
    input  start, len, base_a, base_b, bias, act_en, mem_a_data, mem_b_data,
    output mem_a_en, mem_a_addr, mem_b_en, mem_b_addr, busy, done, result, overflow
  );
endinterface

// File: rtl/cim_dot_product_engine.sv
// Fixed-point dot-product sequencer: streams len element pairs from two read
// memories, accumulates full-precision products, adds a bias, then rounds
// half-up, saturates to DATA_W and optionally applies ReLU.
module cim_dot_product_engine #(
  parameter int DATA_W  = 16,
  parameter int FRAC_W  = 10,
  parameter int ADDR_W  = 12,
  parameter int LEN_W   = 9,
  parameter int MEM_LAT = 1
) (
  input logic                     clk,
  input logic                     rst,
  cim_dot_product_engine_if.slave bus
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int ACC_W  = PROD_W + LEN_W;  // wide enough for 2^LEN_W-1 worst-case products
  localparam int SUM_W  = ACC_W + 1;       // headroom for bias and rounding constant

  localparam logic [MEM_LAT-1:0]      VLD_TOP    = MEM_LAT'(1) << (MEM_LAT - 1);
  localparam logic signed [SUM_W-1:0] ROUND_HALF = SUM_W'(1) << (FRAC_W - 1);
  localparam logic signed [SUM_W-1:0] SAT_MAX    = (SUM_W'(1) << (DATA_W - 1)) - SUM_W'(1);
  localparam logic signed [SUM_W-1:0] SAT_MIN    = -(SUM_W'(1) << (DATA_W - 1));

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Captured command
  logic [LEN_W-1:0]         len_q;
  logic [ADDR_W-1:0]        base_a_q;
  logic [ADDR_W-1:0]        base_b_q;
  logic signed [DATA_W-1:0] bias_q;
  logic                     act_q;

  // Datapath state
  logic [LEN_W-1:0]         cnt_q;    // next element index to issue
  logic signed [ACC_W-1:0]  acc_q;
  logic [MEM_LAT-1:0]       vld_q;    // one bit per read in flight, oldest at the top
  logic                     mem_en_q;
  logic [ADDR_W-1:0]        mem_a_addr_q;
  logic [ADDR_W-1:0]        mem_b_addr_q;
  logic                     busy_q;
  logic                     done_q;
  logic [DATA_W-1:0]        result_q;
  logic                     overflow_q;

  // Decoded control
  logic              accept;
  logic              issue;
  logic              fin;
  logic              drain_last;
  logic [ADDR_W-1:0] issue_addr_a;
  logic [ADDR_W-1:0] issue_addr_b;

  // Arithmetic
  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;
  logic signed [PROD_W-1:0] prod;
  logic signed [SUM_W-1:0]  sum_full;
  logic signed [SUM_W-1:0]  sum_biased;
  logic signed [SUM_W-1:0]  rounded;
  logic [DATA_W-1:0]        final_val;
  logic                     final_ovf;

  assign a_s  = bus.mem_a_data;
  assign b_s  = bus.mem_b_data;
  assign prod = PROD_W'(a_s) * PROD_W'(b_s);

  // The last read is at the top of the valid pipe with nothing younger behind it.
  assign drain_last = vld_q[MEM_LAT-1] && ((vld_q & ~VLD_TOP) == '0);

  // Next-state and issue decode.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    accept       = 1'b0;
    issue        = 1'b0;
    fin          = 1'b0;
    issue_addr_a = base_a_q + ADDR_W'(cnt_q);
    issue_addr_b = base_b_q + ADDR_W'(cnt_q);
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept = 1'b1;
          if (bus.len != '0) begin
            // Element 0 goes out on the accepting edge, straight from the command inputs.
            state_d      = FETCH;
            issue        = 1'b1;
            issue_addr_a = bus.base_a;
            issue_addr_b = bus.base_b;
          end else begin
            state_d = FINISH;
          end
        end
      end
      FETCH: begin
        if (cnt_q == len_q) state_d = DRAIN;
        else                issue   = 1'b1;
      end
      DRAIN: begin
        if (drain_last) state_d = FINISH;
      end
      FINISH: begin
        state_d = IDLE;
        fin     = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bias add, round half up, saturate, then optional ReLU on the final sum.
  always_comb begin
    sum_full   = SUM_W'(acc_q) + (SUM_W'(bias_q) <<< FRAC_W);
    sum_biased = sum_full + ROUND_HALF;
    rounded    = sum_biased >>> FRAC_W;
    final_ovf  = 1'b0;
    final_val  = rounded[DATA_W-1:0];
    if (rounded > SAT_MAX) begin
      final_val = SAT_MAX[DATA_W-1:0];
      final_ovf = 1'b1;
    end else if (rounded < SAT_MIN) begin
      final_val = SAT_MIN[DATA_W-1:0];
      final_ovf = 1'b1;
    end
    if (act_q && final_val[DATA_W-1]) final_val = '0;
  end

  // State, command capture, read issue, accumulation and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      len_q        <= '0;
      base_a_q     <= '0;
      base_b_q     <= '0;
      bias_q       <= '0;
      act_q        <= 1'b0;
      cnt_q        <= '0;
      acc_q        <= '0;
      vld_q        <= '0;
      mem_en_q     <= 1'b0;
      mem_a_addr_q <= '0;
      mem_b_addr_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      result_q     <= '0;
      overflow_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values, independent of statement order within this block.
      state_q  <= state_d;
      done_q   <= fin;
      mem_en_q <= issue;
      vld_q    <= (vld_q << 1) | MEM_LAT'(mem_en_q);

      if (issue) begin
        mem_a_addr_q <= issue_addr_a;
        mem_b_addr_q <= issue_addr_b;
        cnt_q        <= accept ? LEN_W'(1) : cnt_q + 1'b1;
      end

      if (accept) begin
        len_q    <= bus.len;
        base_a_q <= bus.base_a;
        base_b_q <= bus.base_b;
        bias_q   <= bus.bias;
        act_q    <= bus.act_en;
        acc_q    <= '0;
        busy_q   <= 1'b1;
      end else if (vld_q[MEM_LAT-1]) begin
        acc_q <= acc_q + ACC_W'(prod);
      end

      if (fin) begin
        result_q   <= final_val;
        overflow_q <= final_ovf;
        busy_q     <= 1'b0;
      end
    end
  end

  assign bus.mem_a_en   = mem_en_q;
  assign bus.mem_b_en   = mem_en_q;
  assign bus.mem_a_addr = mem_a_addr_q;
  assign bus.mem_b_addr = mem_b_addr_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.result     = result_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_cim_dot_product_engine.sv
// Directed bench for cim_dot_product_engine: one MEM_LAT=1 and one MEM_LAT=3
// instance share a pair of behavioural read memories; expected results come
// from a reference model and are queued at start, then popped at done.
module tb_cim_dot_product_engine;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 10;
  localparam int ADDR_W = 12;
  localparam int LEN_W  = 9;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cim_dot_product_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) if1 ();
  cim_dot_product_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) if3 ();

  cim_dot_product_engine #(
    .DATA_W(DATA_W), .FRAC_W(FRAC_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .MEM_LAT(1)
  ) dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave)
  );

  cim_dot_product_engine #(
    .DATA_W(DATA_W), .FRAC_W(FRAC_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .MEM_LAT(3)
  ) dut3 (
    .clk(clk), .rst(rst), .bus(if3.slave)
  );

  // Shared command drive; sel chooses which instance sees start.
  logic        start    = 1'b0;
  logic        sel      = 1'b0;
  logic [8:0]  cmd_len  = '0;
  logic [11:0] cmd_ba   = '0;
  logic [11:0] cmd_bb   = '0;
  logic [15:0] cmd_bias = '0;
  logic        cmd_act  = 1'b0;

  assign if1.start  = start & ~sel;
  assign if3.start  = start & sel;
  assign if1.len    = cmd_len;
  assign if3.len    = cmd_len;
  assign if1.base_a = cmd_ba;
  assign if3.base_a = cmd_ba;
  assign if1.base_b = cmd_bb;
  assign if3.base_b = cmd_bb;
  assign if1.bias   = cmd_bias;
  assign if3.bias   = cmd_bias;
  assign if1.act_en = cmd_act;
  assign if3.act_en = cmd_act;

  // Behavioural memories with 1- and 3-cycle read pipelines.
  logic [15:0] mem_a [4096];
  logic [15:0] mem_b [4096];
  logic [15:0] pa1 [1];
  logic [15:0] pb1 [1];
  logic [15:0] pa3 [3];
  logic [15:0] pb3 [3];

  always @(posedge clk) begin
    pa1[0] <= mem_a[if1.mem_a_addr];
    pb1[0] <= mem_b[if1.mem_b_addr];
    pa3[0] <= mem_a[if3.mem_a_addr];
    pb3[0] <= mem_b[if3.mem_b_addr];
    pa3[1] <= pa3[0];
    pb3[1] <= pb3[0];
    pa3[2] <= pa3[1];
    pb3[2] <= pb3[1];
  end

  assign if1.mem_a_data = pa1[0];
  assign if1.mem_b_data = pb1[0];
  assign if3.mem_a_data = pa3[2];
  assign if3.mem_b_data = pb3[2];

  // Observation of the selected instance.
  logic        done_s, busy_s, en_a_s, en_b_s, ovf_s;
  logic [11:0] addr_a_s, addr_b_s;
  logic [15:0] result_s;
  assign done_s   = sel ? if3.done       : if1.done;
  assign busy_s   = sel ? if3.busy       : if1.busy;
  assign en_a_s   = sel ? if3.mem_a_en   : if1.mem_a_en;
  assign en_b_s   = sel ? if3.mem_b_en   : if1.mem_b_en;
  assign addr_a_s = sel ? if3.mem_a_addr : if1.mem_a_addr;
  assign addr_b_s = sel ? if3.mem_b_addr : if1.mem_b_addr;
  assign result_s = sel ? if3.result     : if1.result;
  assign ovf_s    = sel ? if3.overflow   : if1.overflow;

  logic [44:0] z1, z3;
  assign z1 = {if1.busy, if1.done, if1.mem_a_en, if1.mem_b_en, if1.mem_a_addr,
               if1.mem_b_addr, if1.result, if1.overflow};
  assign z3 = {if3.busy, if3.done, if3.mem_a_en, if3.mem_b_en, if3.mem_a_addr,
               if3.mem_b_addr, if3.result, if3.overflow};

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] res;
    logic        ovf;
    int          lat;
  } exp_t;

  exp_t        sb [$];
  int          cur_len;
  logic [11:0] cur_ba;
  logic [11:0] cur_bb;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer dot product, bias in Q(2*FRAC), round half up,
  // saturate, then ReLU.
  function automatic exp_t model(input int l, input logic [11:0] ba, input logic [11:0] bb,
                                 input logic [15:0] bi, input logic ac, input int lat);
    exp_t   e;
    longint acc;
    longint r;
    acc = 0;
    for (int k = 0; k < l; k++)
      acc += longint'($signed(mem_a[12'(ba + k)])) * longint'($signed(mem_b[12'(bb + k)]));
    acc += longint'($signed(bi)) * 1024;
    r = (acc + 512) >>> 10;
    e.ovf = 1'b0;
    if (r > 32767) begin
      r = 32767;
      e.ovf = 1'b1;
    end else if (r < -32768) begin
      r = -32768;
      e.ovf = 1'b1;
    end
    if (ac && r < 0) r = 0;
    e.res = r[15:0];
    e.lat = (l == 0) ? 2 : l + lat + 2;
    return e;
  endfunction

  // Drive a command for one cycle's sampling; queue its expectation.
  task automatic issue(input int l, input logic [11:0] ba, input logic [11:0] bb,
                       input logic [15:0] bi, input logic ac, input bit expect_done);
    cmd_len  = 9'(l);
    cmd_ba   = ba;
    cmd_bb   = bb;
    cmd_bias = bi;
    cmd_act  = ac;
    start    = 1'b1;
    cur_len  = l;
    cur_ba   = ba;
    cur_bb   = bb;
    if (expect_done) sb.push_back(model(l, ba, bb, bi, ac, sel ? 3 : 1));
  endtask

  // Wait (bounded) for done, checking the issue sequence on the way.
  task automatic wait_done(input int glitch_cyc, input string tag);
    int   cyc      = 0;
    int   issued   = 0;
    int   aerr     = 0;
    int   busy_err = 0;
    bit   seen     = 1'b0;
    exp_t e;
    while (!seen && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (glitch_cyc != 0 && cyc == glitch_cyc) begin
        cmd_len  = '0;
        cmd_bias = 16'h7fff;
        start    = 1'b1;
      end
      if (glitch_cyc != 0 && cyc == glitch_cyc + 1) start = 1'b0;
      if (en_a_s) begin
        if (addr_a_s !== 12'(cur_ba + issued) || addr_b_s !== 12'(cur_bb + issued) ||
            en_b_s !== 1'b1 || cyc != issued + 1) aerr++;
        issued++;
      end else if (en_b_s) begin
        aerr++;
      end
      if (done_s === 1'b1) seen = 1'b1;
      else if (busy_s !== 1'b1) busy_err++;
    end
    check({tag, "_done_seen"}, 64'(seen), 64'(1));
    if (seen) begin
      check({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check({tag, "_result"},   64'(result_s), 64'(e.res));
        check({tag, "_overflow"}, 64'(ovf_s),    64'(e.ovf));
        check({tag, "_latency"},  64'(cyc),      64'(e.lat));
      end
      check({tag, "_busy_at_done"}, 64'(busy_s), 64'(0));
      check({tag, "_busy_during"},  64'(busy_err), 64'(0));
      check({tag, "_addr_seq"}, {32'(aerr), 32'(issued)}, {32'(0), 32'(cur_len)});
    end
  endtask

  task automatic quiet(input int n, input string tag);
    int extra = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (done_s !== 1'b0) extra++;
    end
    check({tag, "_no_done"}, 64'(extra), 64'(0));
  endtask

  initial begin
    for (int k = 0; k < 4096; k++) begin
      mem_a[k] = '0;
      mem_b[k] = '0;
    end

    // Reset state
    #2 rst = 1'b1;
    #1;
    check("rst_dut1", 64'(z1), 64'(0));
    check("rst_dut3", 64'(z3), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic: 1 + 2 - 1 + 1 = 3.0, plus 0.5 bias -> 3584
    mem_a[100] = 16'd1024; mem_a[101] = 16'd2048; mem_a[102] = 16'hfc00; mem_a[103] = 16'd512;
    mem_b[200] = 16'd1024; mem_b[201] = 16'd1024; mem_b[202] = 16'd1024; mem_b[203] = 16'd2048;
    issue(4, 12'd100, 12'd200, 16'd512, 1'b0, 1'b1);
    wait_done(0, "basic");

    // Positive and negative saturation over 255 elements
    for (int k = 0; k < 255; k++) begin
      mem_a[k]       = 16'h7fff;
      mem_b[512 + k] = 16'h7fff;
    end
    issue(255, 12'd0, 12'd512, 16'd0, 1'b0, 1'b1);
    wait_done(0, "sat_pos");
    for (int k = 0; k < 255; k++) mem_a[k] = 16'h8000;
    issue(255, 12'd0, 12'd512, 16'd0, 1'b0, 1'b1);
    wait_done(0, "sat_neg");

    // Rounding: exactly half an LSB rounds up, just under rounds down
    mem_a[300] = 16'd1; mem_b[400] = 16'd512;
    mem_a[301] = 16'd1; mem_b[401] = 16'd511;
    issue(1, 12'd300, 12'd400, 16'd0, 1'b0, 1'b1);
    wait_done(0, "round_up");
    issue(1, 12'd301, 12'd401, 16'd0, 1'b0, 1'b1);
    wait_done(0, "round_down");

    // ReLU on and off, then zero-length with negative bias
    mem_a[310] = 16'hfc00; mem_b[410] = 16'd1024;
    issue(1, 12'd310, 12'd410, 16'd0, 1'b1, 1'b1);
    wait_done(0, "relu_on");
    issue(1, 12'd310, 12'd410, 16'd0, 1'b0, 1'b1);
    wait_done(0, "relu_off");
    issue(0, 12'd0, 12'd0, 16'hff38, 1'b1, 1'b1);
    wait_done(0, "len0");

    // Three-cycle memory build
    sel = 1'b1;
    issue(2, 12'd100, 12'd200, 16'd0, 1'b0, 1'b1);
    wait_done(0, "lat3");
    sel = 1'b0;

    // Start pulsed while busy must be ignored
    issue(4, 12'd100, 12'd200, 16'd512, 1'b0, 1'b1);
    wait_done(2, "busy_start");
    quiet(8, "busy_start");

    // Back-to-back: second start in the done cycle
    issue(1, 12'd300, 12'd400, 16'd0, 1'b0, 1'b1);
    wait_done(0, "b2b_first");
    issue(1, 12'd310, 12'd410, 16'd0, 1'b0, 1'b1);
    wait_done(0, "b2b_second");

    // Address wrap: 4094, 4095, 0, 1 -> 1 + 2 + 3 - 0.5 = 5.5
    mem_a[4094] = 16'd1024; mem_a[4095] = 16'd2048; mem_a[0] = 16'd3072; mem_a[1] = 16'hfe00;
    for (int k = 0; k < 4; k++) mem_b[600 + k] = 16'd1024;
    issue(4, 12'd4094, 12'd600, 16'd0, 1'b0, 1'b1);
    wait_done(0, "wrap");

    // Asynchronous reset in the middle of fetch
    issue(8, 12'd100, 12'd200, 16'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_mid_outputs", 64'(z1), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    quiet(12, "rst_mid");
    issue(4, 12'd100, 12'd200, 16'd512, 1'b0, 1'b1);
    wait_done(0, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
